ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the rvseed core. It owns the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request channel. It buffers returned instructions with their PCs in a 2-entry queue toward the IDU. It consumes the `next_pc`/`ena` redirect produced by the next-PC mux and supplies `curr_pc` back to it.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `redirect_ena` in 1: branch/jump taken; driven by next-PC mux `ena`.
- `redirect_pc` in `CPU_WIDTH`: redirect target; driven by next-PC mux `next_pc`.
- `curr_pc` out `CPU_WIDTH`: PC of the next request to issue.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out `CPU_WIDTH`: fetch address, word aligned.
- `imem_rsp_valid` in 1: read data valid, exactly one per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_data` in `CPU_WIDTH`: instruction word.
- `idu_valid` out 1: instruction available to decode.
- `idu_ready` in 1: decode accepts.
- `idu_inst` out `CPU_WIDTH`: instruction.
- `idu_inst_pc` out `CPU_WIDTH`: PC of `idu_inst`.

## Operation
- FSM states: REQ, WAIT, FLUSH. Reset state is REQ.
- REQ state:
  - `imem_req_valid` = 1 iff buffer count < 2.
  - `imem_req_addr` = `curr_pc`.
  - On handshake: latch `req_pc` = `curr_pc`, set `curr_pc` += 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0x0), go to WAIT.
  - `imem_rsp_valid` is ignored in REQ.
- WAIT state:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: push {`imem_rsp_data`, `req_pc`} into the buffer, go to REQ.
  - The space check in REQ guarantees the push never overflows.
- FLUSH state:
  - `imem_req_valid` = 0.
  - On `imem_rsp_valid`: discard the data, go to REQ.
- Redirect, when `redirect_ena` = 1. Redirect has priority over every other event in the same cycle.
  - `curr_pc` <= {`redirect_pc`[31:2], 2'b00}.
  - Buffer is cleared, including an entry that would be pushed that cycle.
  - `idu_valid` is forced 0 combinationally that cycle, so no IDU handshake occurs.
  - Next state is FLUSH if a request is outstanding: state WAIT without `imem_rsp_valid`, or a REQ handshake in this same cycle. It is also FLUSH if the current state is FLUSH without `imem_rsp_valid`. Otherwise next state is REQ.
  - A REQ handshake in the redirect cycle does not advance `curr_pc` past the target.
- Buffer: 2-entry in-order FIFO.
  - `idu_valid` = !empty && !`redirect_ena`.
  - Head entry drives `idu_inst`/`idu_inst_pc`.
  - Pops on `idu_valid && idu_ready`.
  - Simultaneous push and pop when full is not possible, because a request is never issued when full.
  - Simultaneous push and pop at count 1 leaves count at 1.
- Reset, including mid-WAIT:
  - `curr_pc` = `RESET_PC`, buffer empty, state REQ.
  - Outputs while `rst` is high: `imem_req_valid` = 0, `idu_valid` = 0, `idu_inst` = 0, `idu_inst_pc` = 0, `curr_pc` = `RESET_PC`.
  - Instruction memory is reset by the same `rst`. A response belonging to a pre-reset request is outside the contract.

## Timing
- First request is visible in the cycle after `rst` falls.
- Request accepted in cycle N: response earliest N+1; `idu_valid` is registered and appears the cycle after the response.
- Peak throughput: one instruction per 2 cycles with zero-wait memory. Only one request is outstanding.
- Redirect in cycle R:
  - With no outstanding request, the target is requested in R+1.
  - Otherwise, the target is requested the cycle after the stale response is dropped.
- No combinational path from `imem_rsp_*` to `imem_req_*`. The only combinational input-to-output path is `redirect_ena` -> `idu_valid`.

## Structure
- Shared define file holds:
  - `CPU_WIDTH` (32).
  - FSM state encodings `FETCH_REQ`, `FETCH_WAIT`, `FETCH_FLUSH`.
  - `PC_STEP` (4).
- Sub-module `fetch_buf`: 2-entry FIFO of {inst, pc} with synchronous `clr`. It exposes `full`, `empty`, and `count`.

## Test plan
- Reset: hold `rst` for 3 cycles, then release with `RESET_PC` = 0x0 -> next cycle shows `imem_req_valid` = 1 and `imem_req_addr` = 0x0. `idu_valid` stays 0 until the first response.
- Zero-wait memory returning 0x13, 0x93, 0x113 with `idu_ready` = 1 -> IDU receives (0x13, 0x0), (0x93, 0x4), (0x113, 0x8) in order, one every 2 cycles.
- `idu_ready` = 0 -> after 2 buffered entries (PCs 0x0, 0x4), `imem_req_valid` stays 0. Raising `idu_ready` drains 0x0 then 0x4, then fetch resumes at 0x8 with no loss or duplication.
- `redirect_ena` = 1 with `redirect_pc` = 0x80 while WAIT for 0x8 -> the 0x8 response is dropped, the next request address is 0x80, and the next IDU pc is 0x80.
- Redirect (`redirect_pc` = 0x103) while buffer is full and `idu_ready` = 1 -> `idu_valid` = 0 that cycle, buffer empties, next request address is 0x100.
- `RESET_PC` = 0xFFFF_FFFC -> second request address is 0x0000_0000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the rvseed instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam logic [CPU_WIDTH-1:0] PC_STEP = 32'd4;
  localparam logic [CPU_WIDTH-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] inst;
    logic [CPU_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel and IDU issue channel of the fetch unit.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [CPU_WIDTH-1:0] imem_rsp_data;
  logic                 idu_valid;
  logic                 idu_ready;
  logic [CPU_WIDTH-1:0] idu_inst;
  logic [CPU_WIDTH-1:0] idu_inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, idu_valid, idu_inst, idu_inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, idu_valid, idu_inst, idu_inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, idu_ready
  );

endinterface

// File: rtl/ifu_fetch_buf.sv
// fetch_buf: 2-entry in-order FIFO of {inst, pc} with synchronous clear.
module ifu_fetch_buf
  import ifu_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Clear wins over a same-cycle push so a redirected stream never leaks through.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: owns the fetch PC, keeps one imem read outstanding and queues results for the IDU.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_ena,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic [CPU_WIDTH-1:0] curr_pc,
  ifu_fetch_if.master          bus
);

  fetch_state_e         state_q;
  logic [CPU_WIDTH-1:0] pc_q;
  logic [CPU_WIDTH-1:0] req_pc_q;

  logic         req_hs;
  logic         push;
  logic         pop;
  logic         flush_next;
  logic         buf_full;
  logic         buf_empty;
  logic [1:0]   buf_count;
  fetch_entry_t buf_head;
  fetch_entry_t push_entry;

  assign curr_pc             = rst ? RESET_PC : pc_q;
  assign bus.imem_req_valid  = !rst && (state_q == FETCH_REQ) && (buf_count < 2'd2);
  assign bus.imem_req_addr   = curr_pc;
  assign req_hs              = bus.imem_req_valid && bus.imem_req_ready;
  assign push                = (state_q == FETCH_WAIT) && bus.imem_rsp_valid && !buf_full;
  assign bus.idu_valid       = !rst && !buf_empty && !redirect_ena;
  assign pop                 = bus.idu_valid && bus.idu_ready;
  assign bus.idu_inst        = rst ? '0 : buf_head.inst;
  assign bus.idu_inst_pc     = rst ? '0 : buf_head.pc;
  assign push_entry.inst     = bus.imem_rsp_data;
  assign push_entry.pc       = req_pc_q;

  // A response is still owed if one is issued now, or WAIT/FLUSH has not seen it yet.
  assign flush_next = req_hs || ((state_q != FETCH_REQ) && !bus.imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect_ena) begin
      pc_q    <= redirect_pc & PC_ALIGN_MASK;
      state_q <= flush_next ? FETCH_FLUSH : FETCH_REQ;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (req_hs) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_STEP;
            state_q  <= FETCH_WAIT;
          end
        end
        FETCH_WAIT, FETCH_FLUSH: begin
          if (bus.imem_rsp_valid) begin
            state_q <= FETCH_REQ;
          end
        end
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  ifu_fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_ena),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, streaming, back-pressure, redirects and PC wrap.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_ena = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] curr_pc;
  logic [31:0] wrap_curr_pc;
  logic        mem_ready = 1'b0;
  logic        idu_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ifu_fetch_if bus ();
  ifu_fetch_if wbus ();

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_ena (redirect_ena),
    .redirect_pc  (redirect_pc),
    .curr_pc      (curr_pc),
    .bus          (bus)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .redirect_ena (1'b0),
    .redirect_pc  (32'h0),
    .curr_pc      (wrap_curr_pc),
    .bus          (wbus)
  );

  // Memory model: response lat cycles after the earliest slot; inst = (addr << 5) | 0x13.
  int unsigned lat = 0;
  int unsigned cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] p_addr = 32'h0;

  assign bus.imem_req_ready = mem_ready;
  assign bus.imem_rsp_valid = pend && (cnt == 0);
  assign bus.imem_rsp_data  = (p_addr << 5) | 32'h13;
  assign bus.idu_ready      = idu_ready;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend   <= 1'b1;
      p_addr <= bus.imem_req_addr;
      cnt    <= lat;
    end else if (pend && cnt == 0) begin
      pend <= 1'b0;
    end else if (pend) begin
      cnt <= cnt - 1;
    end
  end

  logic wrsp_valid = 1'b0;
  assign wbus.imem_req_ready = 1'b1;
  assign wbus.imem_rsp_valid = wrsp_valid;
  assign wbus.imem_rsp_data  = 32'h13;
  assign wbus.idu_ready      = 1'b1;

  always @(posedge clk) begin
    wrsp_valid <= !rst && wbus.imem_req_valid && wbus.imem_req_ready;
  end

  logic [31:0] got_inst[$];
  logic [31:0] got_pc[$];
  int          got_cyc[$];
  logic [31:0] req_addrs[$];
  logic [31:0] wrap_addrs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst && bus.idu_valid && bus.idu_ready) begin
      got_inst.push_back(bus.idu_inst);
      got_pc.push_back(bus.idu_inst_pc);
      got_cyc.push_back(cyc);
    end
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) req_addrs.push_back(bus.imem_req_addr);
    if (!rst && wbus.imem_req_valid && wbus.imem_req_ready) wrap_addrs.push_back(wbus.imem_req_addr);
  end

  task automatic clear_logs();
    got_inst.delete();
    got_pc.delete();
    got_cyc.delete();
    req_addrs.delete();
    wrap_addrs.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_ena = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    lat = 0;
    rst = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (got_pc.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, got %0d instructions, required %0d", name, got_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    idu_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_req_valid: got %b required 0", bus.imem_req_valid);
    end
    if (bus.idu_valid !== 1'b0) begin
      errors++; $display("FAIL rst_idu_valid: got %b required 0", bus.idu_valid);
    end
    if (bus.idu_inst !== 32'h0) begin
      errors++; $display("FAIL rst_idu_inst: got %h required 0", bus.idu_inst);
    end
    if (bus.idu_inst_pc !== 32'h0) begin
      errors++; $display("FAIL rst_idu_inst_pc: got %h required 0", bus.idu_inst_pc);
    end
    if (curr_pc !== 32'h0) begin
      errors++; $display("FAIL rst_curr_pc: got %h required 0", curr_pc);
    end
    if (wrap_curr_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL rst_wrap_curr_pc: got %h required fffffffc", wrap_curr_pc);
    end
    if (wbus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wrap_req_valid: got %b required 0", wbus.imem_req_valid);
    end
    clear_logs();
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL first_req_valid: got %b required 1", bus.imem_req_valid);
    end
    if (bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL first_req_addr: got %h required 0", bus.imem_req_addr);
    end
    if (bus.idu_valid !== 1'b0) begin
      errors++; $display("FAIL first_idu_valid: got %b required 0", bus.idu_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_inst [3] = '{32'h13, 32'h93, 32'h113};
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    mem_ready = 1'b1;
    idu_ready = 1'b1;
    wait_got(3, 40, "stream_timeout");
    mem_ready = 1'b0;
    if (got_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (got_inst[i] !== exp_inst[i]) begin
          errors++; $display("FAIL stream_inst%0d: got %h required %h", i, got_inst[i], exp_inst[i]);
        end
        if (got_pc[i] !== exp_pc[i]) begin
          errors++; $display("FAIL stream_pc%0d: got %h required %h", i, got_pc[i], exp_pc[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (got_cyc[i] - got_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL stream_spacing%0d: got %0d cycles required 2", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    idu_ready = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    repeat (12) @(negedge clk);
    checks += 4;
    if (req_addrs.size() != 2) begin
      errors++; $display("FAIL bp_req_count: got %0d required 2", req_addrs.size());
    end
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL bp_req_valid: got %b required 0", bus.imem_req_valid);
    end
    if (bus.idu_valid !== 1'b1) begin
      errors++; $display("FAIL bp_idu_valid: got %b required 1", bus.idu_valid);
    end
    if (bus.idu_inst_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head_pc: got %h required 0", bus.idu_inst_pc);
    end
    idu_ready = 1'b1;
    wait_got(3, 30, "bp_drain_timeout");
    mem_ready = 1'b0;
    if (got_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (got_pc[i] !== exp_pc[i]) begin
          errors++; $display("FAIL bp_pc%0d: got %h required %h", i, got_pc[i], exp_pc[i]);
        end
        if (got_inst[i] !== ((exp_pc[i] << 5) | 32'h13)) begin
          errors++;
          $display("FAIL bp_inst%0d: got %h required %h", i, got_inst[i], (exp_pc[i] << 5) | 32'h13);
        end
      end
    end
    checks++;
    if (req_addrs.size() < 3 || req_addrs[2] !== 32'h8) begin
      errors++; $display("FAIL bp_resume_addr: got %0d requests, required third at 00000008",
                         req_addrs.size());
    end
  endtask

  task automatic test_redirect_wait();
    int k = 0;
    idu_ready = 1'b1;
    mem_ready = 1'b1;
    do_reset();
    lat = 3;
    while (req_addrs.size() < 3 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_addrs.size() < 3 || req_addrs[2] !== 32'h8) begin
      errors++; $display("FAIL rw_setup: got %0d requests, required third at 00000008",
                         req_addrs.size());
    end
    redirect_ena = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect_ena = 1'b0;
    #1;
    checks += 2;
    if (curr_pc !== 32'h80) begin
      errors++; $display("FAIL rw_curr_pc: got %h required 00000080", curr_pc);
    end
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rw_flush_req_valid: got %b required 0", bus.imem_req_valid);
    end
    wait_got(3, 60, "rw_timeout");
    mem_ready = 1'b0;
    if (got_pc.size() >= 3) begin
      checks += 2;
      if (got_pc[2] !== 32'h80) begin
        errors++; $display("FAIL rw_pc: got %h required 00000080", got_pc[2]);
      end
      if (got_inst[2] !== 32'h1013) begin
        errors++; $display("FAIL rw_inst: got %h required 00001013", got_inst[2]);
      end
    end
    checks++;
    if (req_addrs.size() < 4 || req_addrs[3] !== 32'h80) begin
      errors++; $display("FAIL rw_req_addr: got %0d requests, required fourth at 00000080",
                         req_addrs.size());
    end
  endtask

  task automatic test_redirect_full();
    idu_ready = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.idu_valid !== 1'b1) begin
      errors++; $display("FAIL rf_full_setup: got req_valid %b idu_valid %b required 0 1",
                         bus.imem_req_valid, bus.idu_valid);
    end
    idu_ready = 1'b1;
    redirect_ena = 1'b1;
    redirect_pc = 32'h103;
    #1;
    checks++;
    if (bus.idu_valid !== 1'b0) begin
      errors++; $display("FAIL rf_idu_valid_masked: got %b required 0", bus.idu_valid);
    end
    @(negedge clk);
    redirect_ena = 1'b0;
    #1;
    checks += 5;
    if (got_pc.size() != 0) begin
      errors++; $display("FAIL rf_no_handshake: got %0d pops required 0", got_pc.size());
    end
    if (bus.idu_valid !== 1'b0) begin
      errors++; $display("FAIL rf_buf_empty: got idu_valid %b required 0", bus.idu_valid);
    end
    if (curr_pc !== 32'h100) begin
      errors++; $display("FAIL rf_curr_pc: got %h required 00000100", curr_pc);
    end
    if (bus.imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL rf_req_valid: got %b required 1", bus.imem_req_valid);
    end
    if (bus.imem_req_addr !== 32'h100) begin
      errors++; $display("FAIL rf_req_addr: got %h required 00000100", bus.imem_req_addr);
    end
    wait_got(1, 20, "rf_timeout");
    mem_ready = 1'b0;
    if (got_pc.size() >= 1) begin
      checks++;
      if (got_pc[0] !== 32'h100) begin
        errors++; $display("FAIL rf_first_pc: got %h required 00000100", got_pc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (8) @(negedge clk);
    checks += 2;
    if (wrap_addrs.size() < 2 || wrap_addrs[0] !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first_addr: got %0d requests, required first at fffffffc",
                         wrap_addrs.size());
    end
    if (wrap_addrs.size() < 2 || wrap_addrs[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_second_addr: got %0d requests, required second at 00000000",
                         wrap_addrs.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_full();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
